// File: rtl/sram_device_model.sv
// Cycle-level model of a 64-bit synchronous SRAM with a programmable read latency.
// Optional byte-lane write masking is enabled with `define SRAM_BYTE_LANE_EN.
module sram_device_model #(
    parameter int DEPTH_LOG2   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] SRAM_ADDR,
    input  logic        SRAM_WE_N,
    input  logic        SRAM_CE_N,
    input  logic        SRAM_OE_N,
    input  logic        SRAM_UB_N,
    input  logic        SRAM_LB_N,
    inout  wire  [63:0] SRAM_DQ,
    output logic        rd_valid,
    output logic [15:0] access_cnt
);

    typedef enum logic [1:0] {IDLE, READ_WAIT, READ_DRIVE, WRITE} state_t;

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [2:0] LAT   = 3'(READ_LATENCY);

    state_t                state, next_state;
    logic [2:0]            lat_cnt, next_cnt;
    logic [16:0]           cap_addr, next_addr;
    logic [63:0]           out_reg;
    logic [63:0]           mem [DEPTH];
    logic                  load_out;
    logic                  do_write;
    logic [DEPTH_LOG2-1:0] rd_index;
    logic [DEPTH_LOG2-1:0] wr_index;
    logic [63:0]           wr_mask;

    assign wr_index = SRAM_ADDR[DEPTH_LOG2-1:0];

`ifdef SRAM_BYTE_LANE_EN
    assign wr_mask = {{32{~SRAM_UB_N}}, {32{~SRAM_LB_N}}};
`else
    logic lanes_unused;
    assign lanes_unused = SRAM_UB_N ^ SRAM_LB_N;
    assign wr_mask      = '1;
`endif

    // Write and deselect win from any state; read progress only while selected with WE_N high.
    always_comb begin
        next_state = state;
        next_cnt   = lat_cnt;
        next_addr  = cap_addr;
        load_out   = 1'b0;
        do_write   = 1'b0;
        rd_index   = cap_addr[DEPTH_LOG2-1:0];
        if (SRAM_CE_N) begin
            next_state = IDLE;
        end else if (!SRAM_WE_N) begin
            next_state = WRITE;
            do_write   = 1'b1;
        end else begin
            case (state)
                IDLE, WRITE: begin
                    next_addr = SRAM_ADDR;
                    next_cnt  = 3'd1;
                    if (READ_LATENCY == 1) begin
                        load_out   = 1'b1;
                        rd_index   = SRAM_ADDR[DEPTH_LOG2-1:0];
                        next_state = READ_DRIVE;
                    end else begin
                        next_state = READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (SRAM_ADDR != cap_addr) begin
                        next_addr = SRAM_ADDR;
                        next_cnt  = 3'd1;
                    end else if (lat_cnt == LAT) begin
                        load_out   = 1'b1;
                        next_state = READ_DRIVE;
                    end else begin
                        next_cnt = lat_cnt + 3'd1;
                    end
                end
                READ_DRIVE: begin
                    if (SRAM_ADDR != cap_addr) begin
                        next_addr  = SRAM_ADDR;
                        next_cnt   = 3'd1;
                        next_state = READ_WAIT;
                    end
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            cap_addr   <= '0;
            out_reg    <= '0;
            access_cnt <= '0;
        end else begin
            state    <= next_state;
            lat_cnt  <= next_cnt;
            cap_addr <= next_addr;
            if (load_out) begin
                out_reg <= mem[rd_index];
            end
            if (do_write || load_out) begin
                access_cnt <= access_cnt + 16'd1;
            end
        end
    end

    // The array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_index] <= (mem[wr_index] & ~wr_mask) | (SRAM_DQ & wr_mask);
        end
    end

    assign rd_valid = (state == READ_DRIVE) && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N;
    assign SRAM_DQ  = rd_valid ? out_reg : 'z;

endmodule

// File: doc/sram_device_model.md
SRAM_DEVICE_MODEL -- requirements
Module: sram_device_model

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, meaning the array holds 2^DEPTH_LOG2 words of 64 bits.
REQ-002 SHALL have parameter READ_LATENCY, default 2, meaning cycles from address capture to read data driven; legal range 1..7.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port SRAM_ADDR  input  17  word address from the controller.
REQ-006 SHALL have port SRAM_WE_N  input  1  write enable, active-low.
REQ-007 SHALL have port SRAM_CE_N  input  1  chip enable, active-low.
REQ-008 SHALL have port SRAM_OE_N  input  1  output enable, active-low.
REQ-009 SHALL have port SRAM_UB_N  input  1  upper-lane (bits 63:32) mask, active-low.
REQ-010 SHALL have port SRAM_LB_N  input  1  lower-lane (bits 31:0) mask, active-low.
REQ-011 SHALL have port SRAM_DQ  inout  64  bidirectional data bus.
REQ-012 SHALL have port rd_valid  output  1  high while the model drives valid read data.
REQ-013 SHALL have port access_cnt  output  16  count of completed accesses (writes plus delivered reads).

Function
REQ-014 SHALL index the array with SRAM_ADDR[DEPTH_LOG2-1:0]; higher address bits ignored (addresses alias modulo depth).
REQ-015 SHALL implement states IDLE, READ_WAIT, READ_DRIVE, WRITE.
REQ-016 SHALL, any state, on an edge with CE_N=0 and WE_N=0, enter WRITE and commit DQ to the addressed word at that edge.
REQ-017 SHALL, any state, on an edge with CE_N=1, enter IDLE.
REQ-018 SHALL, from IDLE or WRITE, on an edge with CE_N=0 and WE_N=1, capture SRAM_ADDR, load the latency counter with 1 and enter READ_WAIT.
REQ-019 SHALL, in READ_WAIT with address equal to the captured address, increment the counter each edge; when the counter equals READ_LATENCY, register mem[captured address] into the output register and enter READ_DRIVE.
REQ-020 SHALL, in READ_WAIT or READ_DRIVE, on an edge where SRAM_ADDR differs from the captured address, recapture the address, reset the counter to 1 and enter READ_WAIT.
REQ-021 SHALL, with READ_LATENCY=1, go from IDLE to READ_DRIVE at the capturing edge.
REQ-022 SHALL drive SRAM_DQ from the output register only when state is READ_DRIVE and CE_N=0, OE_N=0, WE_N=1 (combinational gating); otherwise high-impedance.
REQ-023 SHALL give write priority over read when WE_N=0 and OE_N=0 together: no drive, write performed.
REQ-024 SHALL assert rd_valid exactly when REQ-022 drives the bus.
REQ-025 SHALL increment access_cnt by 1 per committed write edge and once per entry into READ_DRIVE; it wraps from 16'hFFFF to 0.
REQ-026 SHALL return, for a read of a word written earlier, the value of the most recent committed write.

Reset
REQ-027 SHALL, while rst=1, force state IDLE, counter 0, captured address 0, output register 0, access_cnt 0, rd_valid 0 and SRAM_DQ high-impedance, independent of clk.
REQ-028 SHALL leave array contents unchanged by reset; reset during READ_WAIT abandons the read without drive.

Configuration
REQ-029 SHALL honour macro SRAM_BYTE_LANE_EN: defined -> writes update bits 63:32 only when UB_N=0 and bits 31:0 only when LB_N=0, and a write with both masks high still counts as an access; undefined -> UB_N/LB_N ignored, every write updates all 64 bits.

Verification
REQ-030 SHALL cover: write 64'h1122334455667788 to addr 5, read addr 5 with READ_LATENCY=2 -> DQ=64'h1122334455667788 and rd_valid=1 exactly 2 edges after capture, access_cnt=2.
REQ-031 SHALL cover: start read of addr 3, change to addr 9 after 1 edge -> no drive until 2 edges after the change, then data of addr 9.
REQ-032 SHALL cover: with SRAM_BYTE_LANE_EN, word 0 = 64'hFFFFFFFF_FFFFFFFF, write 64'h0 with UB_N=1, LB_N=0 -> read gives 64'hFFFFFFFF_00000000; without macro -> 64'h0.
REQ-033 SHALL cover: write addr 17'h00101 with DEPTH_LOG2=8, read addr 1 -> same data (alias).
REQ-034 SHALL cover: assert rst during READ_WAIT -> DQ high-impedance, rd_valid=0, access_cnt=0 immediately; array data preserved on subsequent read.
REQ-035 SHALL cover: WE_N=0 and OE_N=0 together on addr 7 in READ_DRIVE -> bus released that cycle, word written, state WRITE.
